// File: rtl/signal_ext.sv
// Registered immediate sign/zero extender: selects a 9/8/6/4-bit sub-field of
// the instruction immediate and widens it to the datapath width one cycle later.
module signal_ext #(
  parameter int unsigned IN_W  = 9,
  parameter int unsigned OUT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              ext_mode,
  input  logic [1:0]        fld_sel,
  input  logic [IN_W-1:0]   iin,
  output logic [OUT_W-1:0]  outData,
  output logic              out_valid
);

  localparam int unsigned W9 = 9;
  localparam int unsigned W8 = 8;
  localparam int unsigned W6 = 6;
  localparam int unsigned W4 = 4;

  logic [OUT_W-1:0] ext_c;

  // Field select and extension; ext_mode=1 clears the upper bits instead of
  // replicating the field's top bit.
  always_comb begin
    ext_c = '0;
    unique case (fld_sel)
      2'b00: ext_c = {{(OUT_W-W9){iin[W9-1] & ~ext_mode}}, iin[W9-1:0]};
      2'b01: ext_c = {{(OUT_W-W8){iin[W8-1] & ~ext_mode}}, iin[W8-1:0]};
      2'b10: ext_c = {{(OUT_W-W6){iin[W6-1] & ~ext_mode}}, iin[W6-1:0]};
      2'b11: ext_c = {{(OUT_W-W4){iin[W4-1] & ~ext_mode}}, iin[W4-1:0]};
      default: ext_c = '0;
    endcase
  end

  // Output register: loads on en, otherwise holds; valid marks the cycle after a capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outData   <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= en;
      if (en) begin
        outData <= ext_c;
      end
    end
  end

endmodule

// File: tb/tb_signal_ext.sv
// Directed bench for signal_ext: reset, sign/zero extension on every field
// width, hold behaviour and asynchronous reset in the middle of a stream.
module tb_signal_ext;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        ext_mode;
  logic [1:0]  fld_sel;
  logic [8:0]  iin;
  logic [15:0] outData;
  logic        out_valid;

  int checks = 0;
  int errors = 0;

  signal_ext #(.IN_W(9), .OUT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .ext_mode  (ext_mode),
    .fld_sel   (fld_sel),
    .iin       (iin),
    .outData   (outData),
    .out_valid (out_valid)
  );

  // 10 ns clock, first rising edge at 5 ns
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one capture (caller is at a negedge), then check it a cycle later.
  task automatic step(input string tag, input logic [1:0] f, input logic m,
                      input logic [8:0] v, input logic [15:0] exp);
    fld_sel  = f;
    ext_mode = m;
    iin      = v;
    en       = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_data"}, outData, exp);
    check({tag, "_vld"}, 16'(out_valid), 16'h0001);
  endtask

  initial begin
    // Reset asserted at time 0 with a hostile capture pending
    rst_n    = 1'b0;
    en       = 1'b1;
    ext_mode = 1'b0;
    fld_sel  = 2'b00;
    iin      = 9'h1FF;
    #2;
    check("rst_data_noclk", outData, 16'h0000);
    check("rst_vld_noclk", 16'(out_valid), 16'h0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_data_clk", outData, 16'h0000);
    check("rst_vld_clk", 16'(out_valid), 16'h0000);
    rst_n = 1'b1;

    // 9-bit sign extension, back-to-back
    step("s9_1e0", 2'b00, 1'b0, 9'h1E0, 16'hFFE0);
    step("s9_01e", 2'b00, 1'b0, 9'h01E, 16'h001E);
    step("s9_154", 2'b00, 1'b0, 9'h154, 16'hFF54);
    step("s9_180", 2'b00, 1'b0, 9'h180, 16'hFF80);
    step("s9_1aa", 2'b00, 1'b0, 9'h1AA, 16'hFFAA);
    step("s9_001", 2'b00, 1'b0, 9'h001, 16'h0001);

    // Zero extension
    step("z9_1e0", 2'b00, 1'b1, 9'h1E0, 16'h01E0);
    step("z9_1aa", 2'b00, 1'b1, 9'h1AA, 16'h01AA);
    step("z8_1e0", 2'b01, 1'b1, 9'h1E0, 16'h00E0);
    step("z4_00f", 2'b11, 1'b1, 9'h00F, 16'h000F);

    // Narrow fields, sign extension (iin bits above the field ignored)
    step("s8_1e0", 2'b01, 1'b0, 9'h1E0, 16'hFFE0);
    step("s8_07f", 2'b01, 1'b0, 9'h07F, 16'h007F);
    // iin[5:0]=6'b011110: field top bit is 0, so result is positive
    step("s6_01e", 2'b10, 1'b0, 9'h01E, 16'h001E);
    step("s6_1de", 2'b10, 1'b0, 9'h1DE, 16'h001E);
    step("s6_020", 2'b10, 1'b0, 9'h020, 16'hFFE0);
    step("s4_008", 2'b11, 1'b0, 9'h008, 16'hFFF8);
    step("s4_107", 2'b11, 1'b0, 9'h107, 16'h0007);

    // Hold: en=0 while inputs change
    step("hold_cap", 2'b00, 1'b0, 9'h154, 16'hFF54);
    en  = 1'b0;
    iin = 9'h001;
    for (int i = 0; i < 3; i++) begin
      ext_mode = ~ext_mode;
      fld_sel  = 2'(i + 1);
      @(posedge clk);
      @(negedge clk);
      check("hold_data", outData, 16'hFF54);
      check("hold_vld", 16'(out_valid), 16'h0000);
    end

    // Async reset between edges during back-to-back captures
    step("ar_cap0", 2'b00, 1'b0, 9'h1AA, 16'hFFAA);
    fld_sel  = 2'b00;
    ext_mode = 1'b0;
    iin      = 9'h154;
    en       = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_data_now", outData, 16'h0000);
    check("ar_vld_now", 16'(out_valid), 16'h0000);
    @(posedge clk);
    @(negedge clk);
    check("ar_data_held", outData, 16'h0000);
    check("ar_vld_held", 16'(out_valid), 16'h0000);
    rst_n = 1'b1;
    step("ar_180", 2'b00, 1'b0, 9'h180, 16'hFF80);

    // Idle after last capture drops valid
    en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("end_vld", 16'(out_valid), 16'h0000);
    check("end_data", outData, 16'hFF80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
